// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: program-memory geometry, loader state encoding
// and the opcode constants used by the control unit and the loader bench.
package sap1_pkg;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD,
    ST_FULL,
    ST_RELEASE
  } load_state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  function automatic logic [DATA_W-1:0] make_instr(input logic [3:0] opcode,
                                                   input logic [3:0] operand);
    return {opcode, operand};
  endfunction

endpackage

// File: rtl/sap1_program_loader_if.sv
// Bundle of loader pins and CPU read port; master is the pin/CPU side,
// slave is the program loader itself.
interface sap1_program_loader_if;
  import sap1_pkg::*;

  logic              load_mode;
  logic              wr_strobe;
  logic [DATA_W-1:0] wr_data;
  logic              readEnable;
  logic [ADDR_W-1:0] readAddress;
  logic [DATA_W-1:0] dataOut;
  logic              cpu_hold;
  logic [ADDR_W-1:0] load_addr;
  logic              load_done;
  logic              overflow_err;

  modport master (
    output load_mode, wr_strobe, wr_data, readEnable, readAddress,
    input  dataOut, cpu_hold, load_addr, load_done, overflow_err
  );

  modport slave (
    input  load_mode, wr_strobe, wr_data, readEnable, readAddress,
    output dataOut, cpu_hold, load_addr, load_done, overflow_err
  );

endinterface

// File: rtl/sap1_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin plus a registered
// rising-edge pulse of the synchronized level.
module sap1_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // The edge pulse is registered, so a pin edge first sampled at edge N
  // produces a one-cycle pulse visible to the consumer at edge N+STAGES+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
      rise  <= chain[STAGES-1] & ~prev;
    end
  end

  assign level = chain[STAGES-1];

endmodule

// File: rtl/sap1_program_loader.sv
// SAP-1 program RAM with a pin-driven byte loader; holds the CPU in reset
// while loading and serves ROM-compatible registered reads otherwise.
module sap1_program_loader
  import sap1_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sap1_program_loader_if.slave bus
);

  logic load_sync;
  logic load_rise_unused;
  logic strobe_level_unused;
  logic strobe_rise;

  sap1_sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.load_mode),
    .level    (load_sync),
    .rise     (load_rise_unused)
  );

  sap1_sync_edge #(.STAGES(SYNC_STAGES)) u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.wr_strobe),
    .level    (strobe_level_unused),
    .rise     (strobe_rise)
  );

  load_state_t       state, next_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] load_addr;
  logic              load_done;
  logic              overflow_err;
  logic [DATA_W-1:0] data_out;
  logic              cpu_hold;
  logic              last_word;
  logic              do_write;
  logic              start_load;
  logic              flag_overflow;

  assign last_word = (load_addr == ADDR_W'(DEPTH - 1));
  assign cpu_hold  = (state != ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= next_state;
    end
  end

  // Dropping load_mode takes priority over a coincident strobe, so the
  // last byte of an aborted load is discarded rather than half-committed.
  always_comb begin
    next_state    = state;
    do_write      = 1'b0;
    start_load    = 1'b0;
    flag_overflow = 1'b0;
    case (state)
      ST_RUN: begin
        if (load_sync) begin
          next_state = ST_LOAD;
          start_load = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!load_sync) begin
          next_state = ST_RELEASE;
        end else if (strobe_rise) begin
          do_write = 1'b1;
          if (last_word) begin
            next_state = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (!load_sync) begin
          next_state = ST_RELEASE;
        end else if (strobe_rise) begin
          flag_overflow = 1'b1;
        end
      end
      ST_RELEASE: next_state = ST_RUN;
      default:    next_state = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_addr    <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else if (start_load) begin
      load_addr    <= '0;
      load_done    <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (do_write) begin
        load_addr <= last_word ? '0 : load_addr + 1'b1;
        if (last_word) begin
          load_done <= 1'b1;
        end
      end
      if (flag_overflow) begin
        overflow_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[load_addr] <= bus.wr_data;
    end
  end

  // Reads are blanked while the CPU is held, which also rules out a
  // same-cycle read/write collision on one address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (bus.readEnable) begin
      data_out <= cpu_hold ? '0 : mem[bus.readAddress];
    end
  end

  assign bus.dataOut      = data_out;
  assign bus.cpu_hold     = cpu_hold;
  assign bus.load_addr    = load_addr;
  assign bus.load_done    = load_done;
  assign bus.overflow_err = overflow_err;

endmodule

// File: tb/tb_sap1_program_loader.sv
// Directed bench for the SAP-1 program loader: read-back tables after each
// load scenario plus hand-timed sequences for latency and abort corners.
module tb_sap1_program_loader;
  import sap1_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sap1_program_loader_if bus ();

  sap1_program_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] expect_data;
  } read_vec_t;

  read_vec_t         vecs[$];
  int                checks = 0;
  int                errors = 0;
  int                cnt;
  logic [DATA_W-1:0] rd;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic add_vec(input string name, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    read_vec_t v;
    v.name        = name;
    v.addr        = a;
    v.expect_data = d;
    vecs.push_back(v);
  endtask

  task automatic read_word(input logic [ADDR_W-1:0] a, output logic [DATA_W-1:0] d);
    @(negedge clk);
    bus.readEnable  = 1'b1;
    bus.readAddress = a;
    @(posedge clk);
    #1;
    d = bus.dataOut;
    @(negedge clk);
    bus.readEnable = 1'b0;
  endtask

  task automatic apply_stimulus();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < vecs.size(); i++) begin
      read_word(vecs[i].addr, d);
      check_output(vecs[i].name, 32'(d), 32'(vecs[i].expect_data));
    end
    vecs.delete();
  endtask

  task automatic strobe_byte(input logic [DATA_W-1:0] b);
    @(negedge clk);
    bus.wr_data   = b;
    bus.wr_strobe = 1'b1;
    repeat (4) @(negedge clk);
    bus.wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Returns the index of the edge (0 = first edge sampling the strobe high)
  // after which load_addr advanced, or -1 if it never did.
  task automatic strobe_measure(input logic [DATA_W-1:0] b, output int idx);
    logic [ADDR_W-1:0] start;
    start = bus.load_addr;
    idx   = -1;
    @(negedge clk);
    bus.wr_data   = b;
    bus.wr_strobe = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (idx < 0 && bus.load_addr != start) idx = i;
    end
    @(negedge clk);
    bus.wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_hold_low(input int max_cycles, output int n);
    n = 0;
    for (int i = 1; i <= max_cycles; i++) begin
      @(posedge clk);
      #1;
      if (!bus.cpu_hold) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic enter_load();
    @(negedge clk);
    bus.load_mode = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic leave_load(input string name);
    int n;
    @(negedge clk);
    bus.load_mode = 1'b0;
    wait_hold_low(10, n);
    check_output(name, 32'(n), 32'(SYNC_STAGES + 2));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus.load_mode   = 1'b0;
    bus.wr_strobe   = 1'b0;
    bus.wr_data     = '0;
    bus.readEnable  = 1'b0;
    bus.readAddress = '0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cpu_hold", 32'(bus.cpu_hold), 0);
    check_output("reset_load_addr", 32'(bus.load_addr), 0);
    check_output("reset_load_done", 32'(bus.load_done), 0);
    check_output("reset_overflow", 32'(bus.overflow_err), 0);
    check_output("reset_dataOut", 32'(bus.dataOut), 0);
    @(negedge clk);
    rst = 1'b0;
    read_word(4'd5, rd);
    check_output("reset_read_a5", 32'(rd), 0);

    $display("[TB] partial program load");
    enter_load();
    check_output("load_cpu_hold", 32'(bus.cpu_hold), 1);
    strobe_measure(make_instr(OP_LDA, 4'h9), cnt);
    check_output("write_latency", 32'(cnt), 32'(SYNC_STAGES + 1));
    strobe_byte(make_instr(OP_ADD, 4'hA));
    strobe_byte(make_instr(OP_OUT, 4'h0));
    strobe_byte(make_instr(OP_HLT, 4'h0));
    check_output("partial_load_addr", 32'(bus.load_addr), 4);
    check_output("partial_load_done", 32'(bus.load_done), 0);
    leave_load("partial_release_len");
    add_vec("partial_a0", 4'd0, 8'h09);
    add_vec("partial_a1", 4'd1, 8'h1A);
    add_vec("partial_a2", 4'd2, 8'hE0);
    add_vec("partial_a3", 4'd3, 8'hF0);
    add_vec("partial_a4", 4'd4, 8'h00);
    apply_stimulus();
    check_output("partial_run_load_addr", 32'(bus.load_addr), 4);

    $display("[TB] full load and overflow");
    enter_load();
    check_output("reload_addr_cleared", 32'(bus.load_addr), 0);
    read_word(4'd0, rd);
    check_output("read_blanked_in_hold", 32'(rd), 0);
    for (int i = 0; i < 15; i++) strobe_byte(8'h10 + 8'(i));
    check_output("full_15_addr", 32'(bus.load_addr), 15);
    check_output("full_15_done", 32'(bus.load_done), 0);
    strobe_byte(8'h1F);
    check_output("full_16_done", 32'(bus.load_done), 1);
    check_output("full_16_addr", 32'(bus.load_addr), 0);
    check_output("full_16_overflow", 32'(bus.overflow_err), 0);
    strobe_byte(8'hAA);
    check_output("full_17_overflow", 32'(bus.overflow_err), 1);
    check_output("full_17_addr", 32'(bus.load_addr), 0);
    leave_load("full_release_len");
    check_output("full_done_kept", 32'(bus.load_done), 1);
    check_output("full_overflow_sticky", 32'(bus.overflow_err), 1);
    add_vec("full_a15", 4'd15, 8'h1F);
    add_vec("full_a4", 4'd4, 8'h14);
    add_vec("full_a0", 4'd0, 8'h10);
    apply_stimulus();
    @(negedge clk);
    bus.readAddress = 4'd5;
    @(posedge clk);
    #1;
    check_output("dataOut_holds", 32'(bus.dataOut), 32'h10);

    $display("[TB] strobe coincident with load_mode drop");
    enter_load();
    check_output("reenter_done_cleared", 32'(bus.load_done), 0);
    check_output("reenter_overflow_cleared", 32'(bus.overflow_err), 0);
    strobe_byte(8'h55);
    check_output("coinc_pre_addr", 32'(bus.load_addr), 1);
    @(negedge clk);
    bus.wr_data   = 8'h66;
    bus.wr_strobe = 1'b1;
    @(negedge clk);
    bus.load_mode = 1'b0;
    wait_hold_low(10, cnt);
    check_output("coinc_release_len", 32'(cnt), 4);
    @(negedge clk);
    bus.wr_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check_output("coinc_addr_unchanged", 32'(bus.load_addr), 1);
    add_vec("coinc_a0", 4'd0, 8'h55);
    add_vec("coinc_a1", 4'd1, 8'h11);
    apply_stimulus();

    $display("[TB] reset during load");
    enter_load();
    strobe_byte(8'h01);
    strobe_byte(8'h02);
    strobe_byte(8'h03);
    check_output("midload_addr", 32'(bus.load_addr), 3);
    @(negedge clk);
    rst           = 1'b1;
    bus.load_mode = 1'b0;
    #1;
    check_output("midload_rst_hold", 32'(bus.cpu_hold), 0);
    check_output("midload_rst_addr", 32'(bus.load_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    add_vec("midload_a0", 4'd0, 8'h00);
    add_vec("midload_a1", 4'd1, 8'h00);
    add_vec("midload_a2", 4'd2, 8'h00);
    add_vec("midload_a9", 4'd9, 8'h00);
    apply_stimulus();

    $display("[TB] strobes while running");
    strobe_byte(8'h77);
    strobe_byte(8'h78);
    check_output("run_strobe_addr", 32'(bus.load_addr), 0);
    check_output("run_strobe_overflow", 32'(bus.overflow_err), 0);
    check_output("run_strobe_hold", 32'(bus.cpu_hold), 0);
    add_vec("run_strobe_a0", 4'd0, 8'h00);
    apply_stimulus();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap1_program_loader.md
Name: sap1_program_loader

Overview:
- Writer side of the SAP-1 program memory: replaces the fixed 16x8 ROM with a 16x8 RAM that is filled byte-by-byte from the external pins, then read by the CPU.
- Holds the CPU in reset while loading, then releases it.
- Sits between the top-level pins (ui_in/uio_in) and the CPU's MAR/memory read path.
- The CPU read port has the same timing as the existing ROM (registered, one-cycle latency), so the control unit is unchanged.

Parameters:
- DEPTH, 16, number of program words.
- ADDR_W, 4, address width (log2 DEPTH).
- DATA_W, 8, word width.
- SYNC_STAGES, 2, synchronizer flops on pin inputs wr_strobe and load_mode.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- load_mode  in  1  pin level: 1 = loading requested, 0 = run; asynchronous to clk.
- wr_strobe  in  1  pin: a rising edge presents one byte; asynchronous to clk.
- wr_data  in  DATA_W  byte to store; must be stable from before the strobe edge until strobe falls.
- readEnable  in  1  CPU read request.
- readAddress  in  ADDR_W  CPU read address (from MAR).
- dataOut  out  DATA_W  registered CPU read data.
- cpu_hold  out  1  drives CPU reset (OR'd with rst at top level).
- load_addr  out  ADDR_W  next write address.
- load_done  out  1  all DEPTH words written in the current load session.
- overflow_err  out  1  sticky: strobe seen while memory full.

Behaviour:
- Reset (async, rst=1) forces all of the following:
  - State RUN.
  - Memory all 0x00.
  - dataOut=0, cpu_hold=0, load_addr=0, load_done=0, overflow_err=0.
  - Synchronizers and edge-detect history cleared.
- Input conditioning:
  - load_mode and wr_strobe each pass through SYNC_STAGES flops.
  - strobe_rise = synced strobe high AND previous synced value low.
  - A strobe first sampled high at edge N produces the memory write at edge N+SYNC_STAGES+1.
  - wr_data is sampled on that write edge and is not synchronized; the host protocol guarantees stability.
- States:
  - RUN: cpu_hold=0; strobes ignored. Synced load_mode=1 -> LOAD; on entry load_addr=0, load_done=0, overflow_err=0.
  - LOAD: cpu_hold=1.
    - On strobe_rise: mem[load_addr]=wr_data, load_addr+1.
    - The write to address DEPTH-1 -> FULL: load_addr wraps to 0, load_done=1.
    - Synced load_mode=0 -> RELEASE; a partial program is kept and remaining words are unchanged.
  - FULL: cpu_hold=1; strobe_rise writes nothing and sets overflow_err=1 (sticky). Synced load_mode=0 -> RELEASE.
  - RELEASE: cpu_hold=1 for exactly one cycle -> RUN. This guarantees the CPU sees at least one reset cycle after the final write.
- Simultaneous events:
  - strobe_rise in the same cycle that synced load_mode is 0 in LOAD: the byte is discarded and the state goes to RELEASE.
  - load_mode reasserted during RELEASE: ignored; it is re-evaluated in RUN.
- CPU read port:
  - On the clk edge with readEnable=1: dataOut = mem[readAddress], or 0x00 when cpu_hold=1.
  - readEnable=0: dataOut holds its value.
  - A write and a read to the same address in one cycle cannot occur, because reads are gated by cpu_hold.
- load_done is cleared only on entry to LOAD or on reset.
- Reset mid-load: all state is lost, memory returns to 0x00, state RUN.

Decomposition:
- Shared package sap1_pkg holds:
  - the state encoding (RUN, LOAD, FULL, RELEASE);
  - the SAP-1 opcode constants (LDA, ADD, SUB, OUT, HLT), shared with the control unit and the bench.
- One sub-module, sap1_sync_edge, is natural: SYNC_STAGES synchronizer plus rising-edge detect. It is instantiated twice, with the edge output unused for load_mode.
- The RAM array stays inline.

Test Plan:
- Reset then readEnable=1, readAddress=5 -> dataOut=0x00 the next cycle; cpu_hold=0; all flags 0.
- load_mode=1, strobe bytes 0x09,0x1A,0xE0,0xF0, load_mode=0 -> cpu_hold high through RELEASE then low. Reads give addr0=0x09, addr3=0xF0, addr4=0x00; load_addr=4; load_done=0.
- 16 strobes with 0x10..0x1F, then one more strobe 0xAA -> load_done=1 and load_addr=0 after the 16th write. overflow_err=1 after the 17th strobe; addr0 reads 0x10, not 0xAA.
- Strobe edge on the cycle synced load_mode drops -> byte not written, load_addr unchanged, state passes through RELEASE for exactly 1 cycle.
- Assert rst after 3 loaded bytes -> immediate RUN; load_addr=0; addr0..2 read 0x00.
- Strobe pulses in RUN -> no memory change, load_addr stays 0, overflow_err stays 0. Write latency in LOAD is measured as SYNC_STAGES+1 edges.
